// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory bus arbiter.
package mem_bus_arbiter_pkg;

  // Arbiter ownership state: free, or holding the bus for fetch or data.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Snapshot of the granted request; the bus is driven only from this copy.
  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } arb_req_t;

  // Fetches are always one 32-bit word (log2 of 4 bytes).
  localparam logic [2:0] MSIZE4 = 3'd2;

  // Pick the 32-bit instruction word out of a 64-bit bus beat.
  function automatic logic [31:0] select_word(input logic [63:0] beat,
                                              input logic        upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data and shared-bus signals around the arbiter.
//
// Handshake: a requester raises *_req_valid with stable fields and holds it
// until its *_resp_data_ok pulse; addr_ok and data_ok pulse together for one
// cycle. On the shared side creq_valid stays high with stable fields from the
// grant until the cycle in which cresp_ready && cresp_last completes the beat.
interface mem_bus_arbiter_if;

  // Fetch port
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  // Data port
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  // Shared memory bus
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  // Arbiter view
  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data,
    input  cresp_ready, cresp_last, cresp_data
  );

  // Core + memory view
  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data,
    output cresp_ready, cresp_last, cresp_data
  );

endinterface

// File: rtl/mem_bus_arbiter_streak.sv
// Saturating counter of consecutive dbus wins while fetch is waiting.
module arb_streak_counter #(
  parameter int unsigned MAX_COUNT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inc,
  input  logic                             clr,
  output logic [$clog2(MAX_COUNT+1)-1:0]   count,
  output logic                             at_max
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(MAX_COUNT);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over increment; increment stops at the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing a single-beat memory bus between fetch and data.
// Data wins ties so memory-stage stalls clear first; after MAX_D_STREAK data
// grants in a row with fetch waiting, fetch is forced through once.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  mem_bus_arbiter_if.slave                    bus,
  output arb_state_t                          dbg_state,
  output logic [$clog2(MAX_D_STREAK+1)-1:0]   dbg_streak
);

  arb_state_t state_q, state_d;
  arb_req_t   req_q, req_d;
  arb_req_t   out_req;

  logic grant_i;
  logic grant_d;
  logic streak_inc;
  logic streak_clr;
  logic streak_at_max;
  logic beat_done;
  logic i_done;
  logic d_done;

  arb_streak_counter #(
    .MAX_COUNT (MAX_D_STREAK)
  ) u_streak (
    .clk    (clk),
    .reset  (reset),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .count  (dbg_streak),
    .at_max (streak_at_max)
  );

  // A beat finishes only on the last beat of a live grant; a reset in the
  // same cycle suppresses the response so the requester never sees it.
  assign beat_done = (state_q != IDLE) && bus.cresp_ready && bus.cresp_last
                     && !reset;
  assign i_done    = beat_done && (state_q == BUSY_I);
  assign d_done    = beat_done && (state_q == BUSY_D);

  // Next-state, grant choice and request latching.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // Data has priority unless fetch has already waited out a full streak.
        if (bus.dreq_valid && !(bus.ireq_valid && streak_at_max)) begin
          grant_d = 1'b1;
        end else if (bus.ireq_valid) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_d = BUSY_D;
          req_d   = '{is_write: |bus.dreq_strobe,
                      size:     bus.dreq_size,
                      addr:     bus.dreq_addr,
                      strobe:   bus.dreq_strobe,
                      data:     bus.dreq_data};
        end else if (grant_i) begin
          state_d = BUSY_I;
          req_d   = '{is_write: 1'b0,
                      size:     MSIZE4,
                      addr:     bus.ireq_addr,
                      strobe:   8'h00,
                      data:     64'h0};
        end

        // Streak counts data wins only while fetch is actually waiting.
        streak_inc = grant_d && bus.ireq_valid;
        streak_clr = grant_i || !bus.ireq_valid;
      end
      BUSY_I, BUSY_D: begin
        if (beat_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // The shared bus sees the latched copy only while a grant is live.
  always_comb begin
    out_req = '0;
    if (state_q != IDLE) begin
      out_req = req_q;
    end
  end

  assign bus.creq_valid    = (state_q != IDLE);
  assign bus.creq_is_write = out_req.is_write;
  assign bus.creq_size     = out_req.size;
  assign bus.creq_addr     = out_req.addr;
  assign bus.creq_strobe   = out_req.strobe;
  assign bus.creq_data     = out_req.data;

  // Response steering: only the owner sees a pulse, and data is forwarded
  // combinationally in the completing cycle.
  assign bus.iresp_addr_ok = i_done;
  assign bus.iresp_data_ok = i_done;
  assign bus.iresp_data    = i_done ? select_word(bus.cresp_data, req_q.addr[2])
                                    : 32'h0;
  assign bus.dresp_addr_ok = d_done;
  assign bus.dresp_data_ok = d_done;
  assign bus.dresp_data    = d_done ? bus.cresp_data : 64'h0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int MAX_D = 4;
  localparam int W     = 140;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();
  arb_state_t        dbg_state;
  logic [2:0]        dbg_streak;

  mem_bus_arbiter #(
    .MAX_D_STREAK (MAX_D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_chk  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] pack(input logic w, input logic [2:0] s,
                                        input logic [63:0] a,
                                        input logic [7:0] st,
                                        input logic [63:0] d);
    return {w, s, a, st, d};
  endfunction

  function automatic logic [W-1:0] creq_bundle();
    return {bus.creq_is_write, bus.creq_size, bus.creq_addr, bus.creq_strobe,
            bus.creq_data};
  endfunction

  function automatic logic [3:0] resp_oks();
    return {bus.iresp_addr_ok, bus.iresp_data_ok, bus.dresp_addr_ok,
            bus.dresp_data_ok};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = '0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_size   = '0;
    bus.dreq_strobe = '0;
    bus.dreq_data   = '0;
    bus.cresp_ready = 1'b0;
    bus.cresp_last  = 1'b0;
    bus.cresp_data  = '0;
  endtask

  task automatic drive_d(input logic [63:0] a, input logic [2:0] s,
                         input logic [7:0] st, input logic [63:0] d);
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = a;
    bus.dreq_size   = s;
    bus.dreq_strobe = st;
    bus.dreq_data   = d;
  endtask

  task automatic beat(input logic rdy, input logic last, input logic [63:0] d);
    bus.cresp_ready = rdy;
    bus.cresp_last  = last;
    bus.cresp_data  = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model state ----------------
  int   mdl_owner;   // 0 free, 1 fetch, 2 data
  int   mdl_streak;
  logic cur_hi;
  logic i_pend, d_pend;
  int   i_gap, d_gap;
  logic done;
  logic [31:0] exp_word;

  // ---------------- directed + random sequence ----------------
  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_creq_valid", bus.creq_valid, 0);
    chk("rst_creq_fields", creq_bundle(), 0);
    chk("rst_resp_oks", resp_oks(), 0);
    chk("rst_streak", dbg_streak, 0);
    reset = 1'b0;

    // Single fetch, memory answers on the third busy cycle.
    @(negedge clk);
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h8000_0004;
    #1;
    chk("f_no_comb_grant", bus.creq_valid, 0);
    @(negedge clk); #1;
    chk("f_creq_valid", bus.creq_valid, 1);
    chk("f_creq_fields", creq_bundle(), pack(1'b0, 3'd2, 64'h8000_0004, 8'h00, 64'h0));
    chk("f_wait1_quiet", resp_oks(), 0);
    @(negedge clk); #1;
    chk("f_wait2_quiet", resp_oks(), 0);
    @(negedge clk);
    beat(1'b1, 1'b1, 64'h1111_2222_3333_4444);
    #1;
    chk("f_i_oks", {bus.iresp_addr_ok, bus.iresp_data_ok}, 2'b11);
    chk("f_i_data", bus.iresp_data, 32'h1111_2222);
    chk("f_d_quiet", {bus.dresp_addr_ok, bus.dresp_data_ok, bus.dresp_data}, 0);
    @(negedge clk);
    bus.ireq_valid = 1'b0;
    beat(1'b0, 1'b0, 64'h0);
    #1;
    chk("f_back_idle", dbg_state, IDLE);
    chk("f_single_pulse", bus.iresp_data_ok, 0);

    // Collision: data write first, fetch after one idle cycle.
    @(negedge clk);
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h100;
    drive_d(64'h80, 3'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    #1;
    @(negedge clk);
    beat(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    #1;
    chk("c_d_first", dbg_state, BUSY_D);
    chk("c_d_fields", creq_bundle(), pack(1'b1, 3'd3, 64'h80, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D));
    chk("c_streak_one", dbg_streak, 1);
    chk("c_d_pulse_only", resp_oks(), 4'b0011);
    chk("c_d_data", bus.dresp_data, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    bus.dreq_valid = 1'b0;
    beat(1'b0, 1'b0, 64'h0);
    #1;
    chk("c_gap_idle", dbg_state, IDLE);
    chk("c_gap_no_req", bus.creq_valid, 0);
    @(negedge clk);
    beat(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    #1;
    chk("c_i_second", dbg_state, BUSY_I);
    chk("c_i_fields", creq_bundle(), pack(1'b0, 3'd2, 64'h100, 8'h00, 64'h0));
    chk("c_streak_clear", dbg_streak, 0);
    chk("c_i_data_low", bus.iresp_data, 32'hCCCC_DDDD);
    @(negedge clk);
    bus.ireq_valid = 1'b0;
    beat(1'b0, 1'b0, 64'h0);
    #1;
    chk("c_end_idle", dbg_state, IDLE);

    // Starvation guard: both requesters always valid, memory always ready.
    @(negedge clk);
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h200;
    drive_d(64'h300, 3'd3, 8'h00, 64'h0);
    beat(1'b1, 1'b1, 64'h5A5A_5A5A_A5A5_A5A5);
    #1;
    chk("s_start_idle", dbg_state, IDLE);
    for (int g = 0; g < 10; g++) begin
      logic exp_i;
      exp_i = ((g % (MAX_D + 1)) == MAX_D);
      @(negedge clk); #1;
      chk($sformatf("s_owner_%0d", g), dbg_state, exp_i ? BUSY_I : BUSY_D);
      chk($sformatf("s_pulse_%0d", g), {bus.iresp_data_ok, bus.dresp_data_ok},
          exp_i ? 2'b10 : 2'b01);
      chk($sformatf("s_streak_%0d", g), dbg_streak, exp_i ? 0 : (g % (MAX_D + 1)) + 1);
      @(negedge clk); #1;
      chk($sformatf("s_gap_%0d", g), dbg_state, IDLE);
    end
    clear_inputs();

    // Flush: data requester drops valid and scribbles its fields mid-flight.
    @(negedge clk);
    drive_d(64'h2000, 3'd2, 8'h00, 64'h0);
    #1;
    @(negedge clk); #1;
    chk("fl_busy_d", dbg_state, BUSY_D);
    @(negedge clk); #1;
    @(negedge clk);
    drive_d(64'hFFFF_0000, 3'd1, 8'h0F, 64'h5555);
    bus.dreq_valid = 1'b0;
    #1;
    chk("fl_creq_held", creq_bundle(), pack(1'b0, 3'd2, 64'h2000, 8'h00, 64'h0));
    chk("fl_valid_held", bus.creq_valid, 1);
    @(negedge clk);
    beat(1'b1, 1'b1, 64'h0BAD_F00D_1234_5678);
    #1;
    chk("fl_pulse", resp_oks(), 4'b0011);
    chk("fl_data", bus.dresp_data, 64'h0BAD_F00D_1234_5678);
    @(negedge clk);
    beat(1'b0, 1'b0, 64'h0);
    #1;
    chk("fl_idle", dbg_state, IDLE);
    chk("fl_no_req", bus.creq_valid, 0);

    // Reset lands in BUSY_I together with the completing beat.
    @(negedge clk);
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h40;
    #1;
    @(negedge clk);
    reset = 1'b1;
    beat(1'b1, 1'b1, 64'h7777_8888_9999_AAAA);
    #1;
    chk("r_was_busy_i", dbg_state, BUSY_I);
    chk("r_no_pulse", {bus.iresp_addr_ok, bus.iresp_data_ok}, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("r_idle", dbg_state, IDLE);
    chk("r_creq_drop", bus.creq_valid, 0);
    chk("r_req_cleared", creq_bundle(), 0);

    // Spurious ready in IDLE, then a non-last beat in BUSY_D.
    @(negedge clk);
    beat(1'b1, 1'b1, 64'h1);
    #1;
    chk("sp_idle_quiet", resp_oks(), 0);
    @(negedge clk);
    beat(1'b0, 1'b0, 64'h0);
    drive_d(64'h3008, 3'd1, 8'h03, 64'h77);
    #1;
    chk("sp_still_idle", dbg_state, IDLE);
    @(negedge clk);
    beat(1'b1, 1'b0, 64'h2);
    #1;
    chk("sp_busy_d", dbg_state, BUSY_D);
    chk("sp_not_last_quiet", resp_oks(), 0);
    @(negedge clk);
    beat(1'b1, 1'b1, 64'hFEED_0000_0000_BEEF);
    #1;
    chk("sp_held_busy_d", dbg_state, BUSY_D);
    chk("sp_write_fields", creq_bundle(), pack(1'b1, 3'd1, 64'h3008, 8'h03, 64'h77));
    chk("sp_last_pulse", resp_oks(), 4'b0011);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("sp_idle", dbg_state, IDLE);

    // Randomized traffic against the transaction-level model.
    mdl_owner  = 0;
    mdl_streak = 0;
    cur_hi     = 1'b0;
    i_pend     = 1'b0;
    d_pend     = 1'b0;
    i_gap      = 0;
    d_gap      = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!i_pend) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom_range(0, 2) == 0) begin
          i_pend        = 1'b1;
          bus.ireq_addr = {$urandom, $urandom};
        end
      end
      if (!d_pend) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          drive_d({$urandom, $urandom}, 3'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                  {$urandom, $urandom});
        end
      end else begin
        bus.dreq_data = {$urandom, $urandom};
      end
      bus.ireq_valid = i_pend;
      bus.dreq_valid = d_pend;
      if (mdl_owner != 0) begin
        beat(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, {$urandom, $urandom});
      end else begin
        beat($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      end
      #1;
      done = (mdl_owner != 0) && bus.cresp_ready && bus.cresp_last;
      chk("rnd_creq_valid", bus.creq_valid, mdl_owner != 0);
      chk("rnd_streak", dbg_streak, mdl_streak);
      chk("rnd_i_oks", {bus.iresp_addr_ok, bus.iresp_data_ok}, {2{done && (mdl_owner == 1)}});
      chk("rnd_d_oks", {bus.dresp_addr_ok, bus.dresp_data_ok}, {2{done && (mdl_owner == 2)}});
      if (mdl_owner != 0 && exp_q.size() > 0) begin
        chk("rnd_creq_fields", creq_bundle(), exp_q[0]);
        if (mdl_owner == 1) begin
          chk("rnd_d_data_quiet", bus.dresp_data, 0);
          if (done) begin
            exp_word = cur_hi ? bus.cresp_data[63:32] : bus.cresp_data[31:0];
            chk("rnd_i_data", bus.iresp_data, exp_word);
          end
        end else begin
          chk("rnd_i_data_quiet", bus.iresp_data, 0);
          if (done) chk("rnd_d_data", bus.dresp_data, bus.cresp_data);
        end
      end

      // Model update for the next cycle.
      if (done) begin
        void'(exp_q.pop_front());
        if (mdl_owner == 1) begin
          i_pend = 1'b0;
          i_gap  = $urandom_range(0, 2);
        end else begin
          d_pend = 1'b0;
          d_gap  = $urandom_range(0, 2);
        end
        mdl_owner = 0;
      end else if (mdl_owner == 0) begin
        if (d_pend && !(i_pend && mdl_streak == MAX_D)) begin
          mdl_owner = 2;
          exp_q.push_back(pack(|bus.dreq_strobe, bus.dreq_size, bus.dreq_addr,
                               bus.dreq_strobe, bus.dreq_data));
          mdl_streak = i_pend ? ((mdl_streak < MAX_D) ? mdl_streak + 1 : MAX_D) : 0;
        end else if (i_pend) begin
          mdl_owner = 1;
          exp_q.push_back(pack(1'b0, 3'd2, bus.ireq_addr, 8'h00, 64'h0));
          cur_hi     = bus.ireq_addr[2];
          mdl_streak = 0;
        end else begin
          mdl_streak = 0;
        end
      end
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
